// File: rtl/alu4_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu4_sequencer
// Description : Handshaked 4-bit ALU sequencer. Accepts an opcode and operands
//               on a valid/ready input, executes in one cycle (logic/add/sub/
//               shift) or four shift-add cycles (multiply), and holds the
//               registered result on a valid/ready output. An accumulator
//               keeps the last legal low-nibble result for chaining.
// Revision    : 1.0 - initial release
// ============================================================================
module alu4_sequencer #(
  parameter logic [3:0] ACC_INIT = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] op,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       Cin,
  input  logic       use_acc,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out,
  output logic [3:0] out_hi,
  output logic       Cout,
  output logic       zero,
  output logic       err
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NAND = 4'h5;
  localparam logic [3:0] OP_NOR  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       rdy_q, rdy_d;        // holds in_ready low until the first edge after reset
  logic [3:0] op_q, op_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       cin_q, cin_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] prod_q, prod_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] out_q, out_d;
  logic [3:0] out_hi_q, out_hi_d;
  logic       cout_q, cout_d;
  logic       zero_q, zero_d;
  logic       err_q, err_d;

  logic [3:0] alu_res;
  logic       alu_c;
  logic       alu_err;
  logic [4:0] sum5;
  logic [4:0] diff5;
  logic [7:0] addend;
  logic [7:0] prod_next;
  logic       accept;

  // Single-cycle ALU on the captured operands
  always_comb begin
    sum5    = {1'b0, a_q} + {1'b0, b_q} + {4'b0000, cin_q};
    diff5   = {1'b0, a_q} - {1'b0, b_q} - {4'b0000, cin_q};
    alu_res = 4'b0000;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD:  begin alu_res = sum5[3:0];  alu_c = sum5[4];  end
      // Bit 4 of the 5-bit difference is set exactly when the result went negative
      OP_SUB:  begin alu_res = diff5[3:0]; alu_c = diff5[4]; end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NAND: alu_res = ~(a_q & b_q);
      OP_NOR:  alu_res = ~(a_q | b_q);
      OP_XNOR: alu_res = ~(a_q ^ b_q);
      OP_NOT:  alu_res = ~a_q;
      OP_SHL:  begin alu_res = {a_q[2:0], cin_q}; alu_c = a_q[3]; end
      OP_SHR:  begin alu_res = {cin_q, a_q[3:1]}; alu_c = a_q[0]; end
      default: alu_err = 1'b1;
    endcase
  end

  // One shift-add multiply step, multiplier bits consumed LSB first
  always_comb begin
    addend    = b_q[cnt_q] ? ({4'b0000, a_q} << cnt_q) : 8'h00;
    prod_next = prod_q + addend;
  end

  assign accept    = in_valid & in_ready;
  assign in_ready  = rdy_q & (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign Cout      = cout_q;
  assign zero      = zero_q;
  assign err       = err_q;

  // Next-state, operand capture and result registration
  always_comb begin
    state_d  = state_q;
    rdy_d    = 1'b1;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op;
          a_d     = use_acc ? acc_q : x;
          b_d     = y;
          cin_d   = Cin;
          cnt_d   = 2'd0;
          prod_d  = 8'h00;
          state_d = (op == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        out_d    = alu_res;
        out_hi_d = 4'b0000;
        cout_d   = alu_c;
        zero_d   = (alu_res == 4'b0000);
        err_d    = alu_err;
        if (!alu_err) acc_d = alu_res;
        state_d  = S_DONE;
      end
      S_MUL: begin
        prod_d = prod_next;
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          out_d    = prod_next[3:0];
          out_hi_d = prod_next[7:4];
          cout_d   = |prod_next[7:4];
          zero_d   = (prod_next == 8'h00);
          err_d    = 1'b0;
          acc_d    = prod_next[3:0];
          state_d  = S_DONE;
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rdy_q    <= 1'b0;
      op_q     <= 4'h0;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
      cin_q    <= 1'b0;
      cnt_q    <= 2'd0;
      prod_q   <= 8'h00;
      acc_q    <= ACC_INIT;
      out_q    <= 4'h0;
      out_hi_q <= 4'h0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu4_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu4_sequencer
// Description : Directed self-checking bench for alu4_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu4_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [3:0] x;
  logic [3:0] y;
  logic       Cin;
  logic       use_acc;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out;
  logic [3:0] out_hi;
  logic       Cout;
  logic       zero;
  logic       err;

  int n_vec = 0;
  int n_err = 0;

  alu4_sequencer #(.ACC_INIT(4'b0101)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .Cin       (Cin),
    .use_acc   (use_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_hi    (out_hi),
    .Cout      (Cout),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Present one request and hold it until the accept edge
  task automatic send(input string tag, input logic [3:0] o, input logic [3:0] a,
                      input logic [3:0] b, input logic c, input logic ua);
    int k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_ready"}, {7'b0, in_ready}, 8'h01);
    op = o; x = a; y = b; Cin = c; use_acc = ua; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, {7'b0, out_valid}, 8'h00);
  endtask

  // Wait the expected latency and compare the result; flags = {Cout,zero,err}
  task automatic result(input string tag, input int lat, input logic [3:0] hi,
                        input logic [3:0] lo, input logic [2:0] flags);
    repeat (lat - 1) tick();
    chk({tag, "_early"}, {7'b0, out_valid}, 8'h00);
    tick();
    chk({tag, "_valid"}, {7'b0, out_valid}, 8'h01);
    chk({tag, "_data"}, {out_hi, out}, {hi, lo});
    chk({tag, "_flags"}, {5'b0, Cout, zero, err}, {5'b0, flags});
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop"}, {7'b0, out_valid}, 8'h00);
    chk({tag, "_rdy"}, {7'b0, in_ready}, 8'h01);
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [3:0] a,
                     input logic [3:0] b, input logic c, input logic ua,
                     input int lat, input logic [3:0] hi, input logic [3:0] lo,
                     input logic [2:0] flags);
    send(tag, o, a, b, c, ua);
    result(tag, lat, hi, lo, flags);
    handshake(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 4'h0; x = 4'h0; y = 4'h0;
    Cin = 1'b0; use_acc = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_in_ready", {7'b0, in_ready}, 8'h00);
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_data", {out_hi, out}, 8'h00);
    chk("rst_flags", {5'b0, Cout, zero, err}, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    chk("rel_no_ready", {7'b0, in_ready}, 8'h00);
    tick();
    chk("rel_ready", {7'b0, in_ready}, 8'h01);

    // Accumulator starts at ACC_INIT
    run("acc_init", 4'h0, 4'hF, 4'h0, 1'b0, 1'b1, 1, 4'h0, 4'b0101, 3'b000);

    // Add / sub
    run("add1", 4'h0, 4'b1000, 4'b1001, 1'b0, 1'b0, 1, 4'h0, 4'b0001, 3'b100);
    run("add2", 4'h0, 4'b1101, 4'b0110, 1'b1, 1'b0, 1, 4'h0, 4'b0100, 3'b100);
    run("sub_brw", 4'h1, 4'b0101, 4'b0101, 1'b1, 1'b0, 1, 4'h0, 4'b1111, 3'b100);
    run("sub_eq", 4'h1, 4'b0110, 4'b0101, 1'b1, 1'b0, 1, 4'h0, 4'b0000, 3'b010);

    // Logic and shifts
    run("and", 4'h2, 4'b1100, 4'b1010, 1'b1, 1'b0, 1, 4'h0, 4'b1000, 3'b000);
    run("or", 4'h3, 4'b1100, 4'b1010, 1'b0, 1'b0, 1, 4'h0, 4'b1110, 3'b000);
    run("xor", 4'h4, 4'b1010, 4'b0110, 1'b0, 1'b0, 1, 4'h0, 4'b1100, 3'b000);
    run("nand", 4'h5, 4'b1100, 4'b1010, 1'b0, 1'b0, 1, 4'h0, 4'b0111, 3'b000);
    run("nor", 4'h6, 4'b1100, 4'b1010, 1'b0, 1'b0, 1, 4'h0, 4'b0001, 3'b000);
    run("xnor", 4'h7, 4'b1010, 4'b0110, 1'b0, 1'b0, 1, 4'h0, 4'b0011, 3'b000);
    run("not", 4'h8, 4'b0101, 4'b1111, 1'b1, 1'b0, 1, 4'h0, 4'b1010, 3'b000);
    run("shl", 4'h9, 4'b1011, 4'b0000, 1'b1, 1'b0, 1, 4'h0, 4'b0111, 3'b100);
    run("shr", 4'hA, 4'b1011, 4'b0000, 1'b1, 1'b0, 1, 4'h0, 4'b1101, 3'b100);

    // Multiply
    run("mul1", 4'hB, 4'b1101, 4'b0110, 1'b0, 1'b0, 4, 4'b0100, 4'b1110, 3'b100);
    run("mul2", 4'hB, 4'b0011, 4'b0101, 1'b1, 1'b0, 4, 4'b0000, 4'b1111, 3'b000);
    run("mul_max", 4'hB, 4'b1111, 4'b1111, 1'b0, 1'b0, 4, 4'hE, 4'h1, 3'b100);
    run("mul_zero", 4'hB, 4'b0101, 4'b0000, 1'b0, 1'b0, 4, 4'h0, 4'h0, 3'b010);

    // Backpressure: result held, requests ignored
    send("bp", 4'h0, 4'b0001, 4'b0001, 1'b0, 1'b0);
    result("bp", 1, 4'h0, 4'b0010, 3'b000);
    for (int i = 0; i < 5; i++) begin
      op = 4'h0; x = 4'hF; y = 4'hF; in_valid = 1'b1;
      tick();
      chk("bp_hold_data", {out_hi, out}, 8'h02);
      chk("bp_hold_valid", {7'b0, out_valid}, 8'h01);
      chk("bp_hold_rdy", {7'b0, in_ready}, 8'h00);
    end
    in_valid = 1'b0;
    handshake("bp");
    tick();
    chk("bp_no_ghost", {7'b0, out_valid}, 8'h00);
    chk("bp_idle_data", {out_hi, out}, 8'h02);

    // Accumulator chain
    run("ch1", 4'h0, 4'b0011, 4'b0100, 1'b0, 1'b0, 1, 4'h0, 4'b0111, 3'b000);
    run("ch2", 4'h0, 4'b1111, 4'b1001, 1'b0, 1'b1, 1, 4'h0, 4'b0000, 3'b110);
    run("ch3", 4'h1, 4'b1111, 4'b0001, 1'b0, 1'b1, 1, 4'h0, 4'b1111, 3'b100);

    // Illegal opcode leaves accumulator untouched
    run("il_pre", 4'h0, 4'b0011, 4'b0100, 1'b0, 1'b0, 1, 4'h0, 4'b0111, 3'b000);
    run("illegal", 4'hE, 4'b1111, 4'b1111, 1'b1, 1'b0, 1, 4'h0, 4'b0000, 3'b011);
    run("il_post", 4'h0, 4'b1111, 4'b0000, 1'b0, 1'b1, 1, 4'h0, 4'b0111, 3'b000);

    // Reset in the middle of a multiply
    send("rmul", 4'hB, 4'b1111, 4'b1111, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rmul_valid", {7'b0, out_valid}, 8'h00);
    chk("rmul_data", {out_hi, out}, 8'h00);
    chk("rmul_flags", {5'b0, Cout, zero, err}, 8'h00);
    chk("rmul_rdy", {7'b0, in_ready}, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("rmul_rel_rdy", {7'b0, in_ready}, 8'h01);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rmul_no_valid", {7'b0, out_valid}, 8'h00);
    end
    run("rmul_acc", 4'h0, 4'hF, 4'h0, 1'b0, 1'b1, 1, 4'h0, 4'b0101, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu4_sequencer.md
# alu4_sequencer

Sequential front end for the team's 4-bit operation units (add, sub, and, or, xor, nand, nor, xnor, not, shift, mult). A requester presents an opcode and operands over a valid/ready handshake. The block executes the operation, taking one cycle for logic and add/sub/shift and four shift-add iterations for multiply. It then holds the registered result on an output valid/ready handshake. An internal accumulator lets a requester chain operations without re-supplying x.

## Interface

Parameters:
- ACC_INIT, 4'b0000, accumulator value after reset

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- op  in  4  opcode (below)
- x  in  4  operand A
- y  in  4  operand B
- Cin  in  1  carry/borrow/shift-in
- use_acc  in  1  1: operand A = accumulator instead of x
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- out  out  4  result low nibble
- out_hi  out  4  product high nibble (MUL), else 0
- Cout  out  1  carry/borrow/shift-out flag
- zero  out  1  out == 0 (and out_hi == 0 for MUL)
- err  out  1  illegal opcode flag

## Operation

- Opcodes:
  - 0 ADD
  - 1 SUB
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NAND
  - 6 NOR
  - 7 XNOR
  - 8 NOT
  - 9 SHL
  - A SHR
  - B MUL
  - C–F illegal
- Operand A, B, Cin and op are captured on the accept edge (in_valid & in_ready). Inputs are ignored at all other times.
- ADD: {Cout,out} = A + y + Cin.
- SUB: out = (A − y − Cin) mod 16; Cout = 1 iff A < y + Cin (borrow).
- AND/OR/XOR/NAND/NOR/XNOR: bitwise on A,y; Cout = 0.
- NOT: out = ~A; Cout = 0.
- SHL: out = {A[2:0],Cin}; Cout = A[3].
- SHR: out = {Cin,A[3:1]}; Cout = A[0].
- MUL: {out_hi,out} = A × y, unsigned 8-bit product. Computed by 4 shift-add iterations, one per cycle, LSB of y first. Cin is ignored. Cout = (out_hi != 0).
- out_hi = 0 for every non-MUL op.
- Illegal op: out = 0, out_hi = 0, Cout = 0, zero = 1, err = 1. Accumulator is unchanged. err = 0 for legal ops.
- Accumulator loads out (low nibble) when a legal result is registered. Illegal ops do not update it.
- State machine:
  - IDLE: in_ready = 1. On accept, go to EXEC for non-MUL ops, or MUL with iteration count 0.
  - EXEC: compute, register the result, go to DONE.
  - MUL: one add/shift per cycle. After the 4th iteration, register the result and go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE. Otherwise hold all outputs stable.

## Timing

- Reset (async assert, synchronous-looking release on next edge):
  - state = IDLE
  - in_ready = 0 while rst = 1, 1 from the first edge after release
  - out_valid = 0; out = 0; out_hi = 0; Cout = 0; zero = 0; err = 0
  - accumulator = ACC_INIT
- Reset mid-operation (EXEC/MUL/DONE) aborts immediately. The partial result is discarded and no out_valid pulse occurs.
- Latency from the accept edge N:
  - non-MUL and illegal ops: out_valid high after edge N+1
  - MUL: out_valid high after edge N+4, i.e. 4 cycles in MUL state
- Result handshake completes on an edge with out_valid & out_ready. out_valid falls after that edge, and in_ready rises after the same edge.
- in_ready = 0 in EXEC, MUL and DONE. No request is accepted in the same cycle as an output handshake.
- Maximum throughput: one non-MUL op per 3 cycles when out_ready is held at 1.
- Outputs out, out_hi, Cout, zero and err are registered. They change only on entering DONE or on reset, and stay stable through IDLE until the next result.
- An accept while use_acc = 1 uses the accumulator value present before that edge.

## Test plan

- ADD, x=1000 y=1001 Cin=0 -> out=0001 Cout=1 zero=0, out_valid 1 cycle after accept. Then x=1101 y=0110 Cin=1 -> out=0100 Cout=1.
- MUL x=1101 y=0110 -> out_hi=0100 out=1110 Cout=1, out_valid 4 cycles after accept. MUL x=0011 y=0101 -> out_hi=0000 out=1111 Cout=0.
- Backpressure: ADD 0001+0001 with out_ready=0 for 5 cycles -> out=0010 held stable, in_ready=0 throughout, in_valid pulses ignored. Release out_ready -> in_ready=1 next cycle.
- Accumulator chain: ADD x=0011 y=0100 (out 0111), then ADD use_acc=1 y=1001 Cin=0 -> out=0000 Cout=1 zero=1. Then SUB use_acc=1 y=0001 -> out=1111 Cout=1.
- Illegal op=1110 after acc=0111 -> err=1 out=0000 zero=1. A following ADD use_acc=1 y=0000 -> out=0111, proving the accumulator was unchanged.
- Reset mid-MUL: assert rst 2 cycles after MUL accept -> outputs immediately 0, no out_valid. After release, in_ready=1 and accumulator = ACC_INIT.
